// File: rtl/dm_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Zero latency; no backpressure (types and constants only).
package dm_arb_pkg;

   localparam int DM_ARB_DW        = 16;
   localparam int DM_ARB_AW        = 9;
   localparam int DM_ARB_BURST_MAX = 8;

   // Records which port owned the memory last; LOCK_L is a loader burst.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAST_C = 2'd1,
      LAST_L = 2'd2,
      LOCK_L = 2'd3
   } dm_arb_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Core port, loader port and data-memory port of the arbiter in one bundle.
// Zero latency; grants are the only backpressure (requesters hold until granted).
interface dm_arbiter_if
   import dm_arb_pkg::*;
#(
   parameter int DW = DM_ARB_DW,
   parameter int AW = DM_ARB_AW
);

   logic          C_REQ;
   logic          C_WE;
   logic [AW-1:0] C_ADDR;
   logic [DW-1:0] C_WDATA;
   logic          C_GNT;
   logic          C_VALID;
   logic [DW-1:0] C_RDATA;
   logic          C_STALL;

   logic          L_REQ;
   logic          L_WE;
   logic          L_LOCK;
   logic [AW-1:0] L_ADDR;
   logic [DW-1:0] L_WDATA;
   logic          L_GNT;
   logic          L_VALID;
   logic [DW-1:0] L_RDATA;

   logic [AW-1:0] DM_ADDR;
   logic [DW-1:0] DM_IN;
   logic          DM_ED;
   logic [DW-1:0] DM_OUT;

   // Requesters and the memory model together.
   modport master (
      output C_REQ, C_WE, C_ADDR, C_WDATA,
      input  C_GNT, C_VALID, C_RDATA, C_STALL,
      output L_REQ, L_WE, L_LOCK, L_ADDR, L_WDATA,
      input  L_GNT, L_VALID, L_RDATA,
      input  DM_ADDR, DM_IN, DM_ED,
      output DM_OUT
   );

   modport slave (
      input  C_REQ, C_WE, C_ADDR, C_WDATA,
      output C_GNT, C_VALID, C_RDATA, C_STALL,
      input  L_REQ, L_WE, L_LOCK, L_ADDR, L_WDATA,
      output L_GNT, L_VALID, L_RDATA,
      output DM_ADDR, DM_IN, DM_ED,
      input  DM_OUT
   );

endinterface

// File: rtl/dm_arb_rr.sv
// Two-way round-robin grant decode from the last-owner state; purely combinational.
// Zero latency; a losing requester is simply not granted and must hold its request.
module dm_arb_rr
   import dm_arb_pkg::*;
(
   input  dm_arb_state_e state,
   input  logic          c_req,
   input  logic          l_req,
   input  logic          lock_go,
   output logic          gnt_c,
   output logic          gnt_l
);

   always_comb begin
      gnt_c = 1'b0;
      gnt_l = 1'b0;
      case (state)
         // Burst owner: core never wins; loader wins only while the burst may continue.
         LOCK_L: gnt_l = l_req & lock_go;
         LAST_C: begin
            gnt_l = l_req;
            gnt_c = c_req & ~l_req;
         end
         default: begin
            gnt_c = c_req;
            gnt_l = l_req & ~c_req;
         end
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Core/loader data-memory arbiter; accesses complete in the grant cycle, read data valid one cycle later.
// Backpressure is the grant itself (C_STALL for the core); DM_ARB_LOCK_EN adds locked loader bursts.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DW        = DM_ARB_DW,
   parameter int AW        = DM_ARB_AW,
   parameter int BURST_MAX = DM_ARB_BURST_MAX
)(
   input  logic         CLK,
   input  logic         RST,
   dm_arbiter_if.slave  bus
);

   localparam int CW = $clog2(BURST_MAX + 1);

   dm_arb_state_e state;
   logic          c_req;
   logic          l_req;
   logic          gnt_c;
   logic          gnt_l;
   logic          lock_go;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_in;
   logic          dm_ed;

   // Requests are masked while reset is held so no access can slip through.
   assign c_req = bus.C_REQ & RST;
   assign l_req = bus.L_REQ & RST;

`ifdef DM_ARB_LOCK_EN
   logic [CW-1:0] lock_cnt;
   assign lock_go = bus.L_LOCK && (lock_cnt != CW'(BURST_MAX));
`else
   logic          unused_lock;
   logic [CW-1:0] unused_burst_max;
   assign unused_lock      = bus.L_LOCK;
   assign unused_burst_max = CW'(BURST_MAX);
   assign lock_go          = 1'b0;
`endif

   dm_arb_rr u_rr (
      .state   (state),
      .c_req   (c_req),
      .l_req   (l_req),
      .lock_go (lock_go),
      .gnt_c   (gnt_c),
      .gnt_l   (gnt_l)
   );

   always_comb begin
      dm_addr = '0;
      dm_in   = '0;
      dm_ed   = 1'b0;
      if (gnt_c) begin
         dm_addr = bus.C_ADDR;
         dm_in   = bus.C_WDATA;
         dm_ed   = bus.C_WE;
      end else if (gnt_l) begin
         dm_addr = bus.L_ADDR;
         dm_in   = bus.L_WDATA;
         dm_ed   = bus.L_WE;
      end
   end

   assign bus.DM_ADDR = dm_addr;
   assign bus.DM_IN   = dm_in;
   assign bus.DM_ED   = dm_ed;
   assign bus.C_GNT   = gnt_c;
   assign bus.L_GNT   = gnt_l;
   assign bus.C_STALL = c_req & ~gnt_c;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= IDLE;
         bus.C_RDATA <= '0;
         bus.L_RDATA <= '0;
         bus.C_VALID <= 1'b0;
         bus.L_VALID <= 1'b0;
`ifdef DM_ARB_LOCK_EN
         lock_cnt    <= '0;
`endif
      end else begin
         bus.C_VALID <= gnt_c & ~bus.C_WE;
         bus.L_VALID <= gnt_l & ~bus.L_WE;
         if (gnt_c && !bus.C_WE) bus.C_RDATA <= bus.DM_OUT;
         if (gnt_l && !bus.L_WE) bus.L_RDATA <= bus.DM_OUT;

         if (gnt_c) begin
            state <= LAST_C;
         end else if (gnt_l) begin
`ifdef DM_ARB_LOCK_EN
            if (state == LOCK_L) begin
               lock_cnt <= lock_cnt + CW'(1);
            end else if (bus.L_LOCK) begin
               // Counter restarts with the burst; the entry grant is its first grant.
               state    <= LOCK_L;
               lock_cnt <= CW'(1);
            end else begin
               state <= LAST_L;
            end
`else
            state <= LAST_L;
`endif
         end
`ifdef DM_ARB_LOCK_EN
         else if (state == LOCK_L) begin
            // Release cycle: nobody is granted, so a waiting core wins from LAST_L next.
            state <= LAST_L;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed vectors push expected outputs, a negedge monitor compares.
// Lock-burst expectations follow DM_ARB_LOCK_EN.
module tb_dm_arbiter;
   import dm_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dm_arbiter_if #(.DW(16), .AW(9)) bus ();

   dm_arbiter #(.DW(16), .AW(9), .BURST_MAX(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic        cg, lg, cs, ed, cv, lv;
      logic [8:0]  addr;
      logic [15:0] din, crd, lrd;
   } exp_t;

   exp_t q[$];
   int checks   = 0;
   int failures = 0;

   function automatic exp_t mk(input string n, input int cg, input int lg, input int cs, input int ed,
                               input int addr, input int din, input int cv, input int crd,
                               input int lv, input int lrd);
      exp_t e;
      e.name = n;
      e.cg   = 1'(cg);
      e.lg   = 1'(lg);
      e.cs   = 1'(cs);
      e.ed   = 1'(ed);
      e.addr = 9'(addr);
      e.din  = 16'(din);
      e.cv   = 1'(cv);
      e.crd  = 16'(crd);
      e.lv   = 1'(lv);
      e.lrd  = 16'(lrd);
      return e;
   endfunction

   task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s.%s got=%h want=%h", n, f, act, want);
      end
   endtask

   // Drive one cycle of stimulus, queue what the outputs must be in that cycle, advance.
   task automatic cyc(input int r, input int cr, input int cw, input int ca, input int cd,
                      input int lr, input int lw, input int lk, input int la, input int ld,
                      input int mo, input exp_t e);
      rst         = 1'(r);
      bus.C_REQ   = 1'(cr);
      bus.C_WE    = 1'(cw);
      bus.C_ADDR  = 9'(ca);
      bus.C_WDATA = 16'(cd);
      bus.L_REQ   = 1'(lr);
      bus.L_WE    = 1'(lw);
      bus.L_LOCK  = 1'(lk);
      bus.L_ADDR  = 9'(la);
      bus.L_WDATA = 16'(ld);
      bus.DM_OUT  = 16'(mo);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "C_GNT",   16'(bus.C_GNT),   16'(e.cg));
            chk(e.name, "L_GNT",   16'(bus.L_GNT),   16'(e.lg));
            chk(e.name, "C_STALL", 16'(bus.C_STALL), 16'(e.cs));
            chk(e.name, "DM_ED",   16'(bus.DM_ED),   16'(e.ed));
            chk(e.name, "DM_ADDR", 16'(bus.DM_ADDR), 16'(e.addr));
            chk(e.name, "DM_IN",   bus.DM_IN,        e.din);
            chk(e.name, "C_VALID", 16'(bus.C_VALID), 16'(e.cv));
            chk(e.name, "C_RDATA", bus.C_RDATA,      e.crd);
            chk(e.name, "L_VALID", 16'(bus.L_VALID), 16'(e.lv));
            chk(e.name, "L_RDATA", bus.L_RDATA,      e.lrd);
         end
      end
   end

   initial begin
      int   pc, pl, crd, lrd, cg, lg;
      rst = 1'b0;
      bus.C_REQ = 1'b0; bus.C_WE = 1'b0; bus.C_ADDR = '0; bus.C_WDATA = '0;
      bus.L_REQ = 1'b0; bus.L_WE = 1'b0; bus.L_LOCK = 1'b0; bus.L_ADDR = '0; bus.L_WDATA = '0;
      bus.DM_OUT = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset gating, idle, then strict alternation from IDLE with reads on both ports.
      cyc(0, 1,1,'h003,'h0007, 1,1,0,'h004,'h0008, 'h0000, mk("rst_hold",   0,0,0,0,'h000,'h0000, 0,'h0000, 0,'h0000));
      cyc(1, 0,0,'h000,'h0000, 0,0,0,'h000,'h0000, 'h0000, mk("idle",       0,0,0,0,'h000,'h0000, 0,'h0000, 0,'h0000));
      cyc(1, 1,0,'h010,'h0000, 1,0,0,'h020,'h0000, 'h1111, mk("alt1",       1,0,0,0,'h010,'h0000, 0,'h0000, 0,'h0000));
      cyc(1, 1,0,'h010,'h0000, 1,0,0,'h020,'h0000, 'h2222, mk("alt2",       0,1,1,0,'h020,'h0000, 1,'h1111, 0,'h0000));
      cyc(1, 1,0,'h010,'h0000, 1,0,0,'h020,'h0000, 'h3333, mk("alt3",       1,0,0,0,'h010,'h0000, 0,'h1111, 1,'h2222));
      cyc(1, 1,0,'h010,'h0000, 1,0,0,'h020,'h0000, 'h4444, mk("alt4",       0,1,1,0,'h020,'h0000, 1,'h3333, 0,'h2222));
      cyc(1, 0,0,'h000,'h0000, 0,0,0,'h000,'h0000, 'h0000, mk("idle2",      0,0,0,0,'h000,'h0000, 0,'h3333, 1,'h4444));
      // Single core read, single loader write at the top address.
      cyc(1, 1,0,'h005,'h0000, 0,0,0,'h000,'h0000, 'h1234, mk("c_rd",       1,0,0,0,'h005,'h0000, 0,'h3333, 0,'h4444));
      cyc(1, 0,0,'h000,'h0000, 1,1,0,'h1FF,'hBEEF, 'h0000, mk("l_wr",       0,1,0,1,'h1FF,'hBEEF, 1,'h1234, 0,'h4444));
      cyc(1, 0,0,'h000,'h0000, 0,0,0,'h000,'h0000, 'h0000, mk("l_wr_after", 0,0,0,0,'h000,'h0000, 0,'h1234, 0,'h4444));
      // Core write alone, then contention resolved by last owner.
      cyc(1, 1,1,'h0AA,'h5A5A, 0,0,0,'h000,'h0000, 'h0000, mk("c_wr",       1,0,0,1,'h0AA,'h5A5A, 0,'h1234, 0,'h4444));
      cyc(1, 1,1,'h0AA,'h5A5A, 1,0,0,'h033,'h0000, 'h6666, mk("l_over_c",   0,1,1,0,'h033,'h0000, 0,'h1234, 0,'h4444));
      cyc(1, 1,1,'h0AA,'h5A5A, 1,0,0,'h033,'h0000, 'h7777, mk("c_over_l",   1,0,0,1,'h0AA,'h5A5A, 0,'h1234, 1,'h6666));
      cyc(0, 1,1,'h0AA,'h5A5A, 1,1,0,'h033,'h0000, 'h0000, mk("rst2",       0,0,0,0,'h000,'h0000, 0,'h1234, 0,'h6666));

      // Both requesting with L_LOCK=1 from IDLE.
      pc = 0; pl = 0; crd = 0; lrd = 0;
      for (int i = 0; i < 13; i++) begin
`ifdef DM_ARB_LOCK_EN
         cg = (i == 0 || i == 10) ? 1 : 0;
         lg = ((i >= 1 && i <= 8) || i == 11 || i == 12) ? 1 : 0;
`else
         cg = (i % 2 == 0) ? 1 : 0;
         lg = 1 - cg;
`endif
         cyc(1, 1,0,'h010,'h0000, 1,0,1,'h020,'h0000, 'h0100 + i,
             mk($sformatf("burst%0d", i), cg, lg, 1 - cg, 0, cg ? 'h010 : (lg ? 'h020 : 'h000), 'h0000,
                pc, crd, pl, lrd));
         if (cg != 0) crd = 'h0100 + i;
         if (lg != 0) lrd = 'h0100 + i;
         pc = cg;
         pl = lg;
      end

      // Reset in the middle of the burst with a loader write pending.
      cyc(0, 1,0,'h010,'h0000, 1,1,1,'h020,'hDEAD, 'h0000, mk("rst_lock",    0,0,0,0,'h000,'h0000, pc,crd, pl,lrd));
      cyc(0, 1,0,'h010,'h0000, 1,1,1,'h020,'hDEAD, 'h0000, mk("rst_lock2",   0,0,0,0,'h000,'h0000, 0,'h0000, 0,'h0000));
      cyc(1, 1,0,'h010,'h0000, 1,0,0,'h020,'h0000, 'h0900, mk("rst_c_first", 1,0,0,0,'h010,'h0000, 0,'h0000, 0,'h0000));
      cyc(1, 1,0,'h010,'h0000, 1,0,0,'h020,'h0000, 'h0A00, mk("rst_l_next",  0,1,1,0,'h020,'h0000, 1,'h0900, 0,'h0000));

      bus.C_REQ = 1'b0;
      bus.L_REQ = 1'b0;
      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
